cnn_layer_accel_job_ctrl: RTL and testbench

- Job sequencer in front of cnn_layer_accel_quad.
- Accepts 128-bit job descriptors from the host into a small queue and issues them one at a time on the quad job interface.
- Brokers the quad's fetch handshake to the input DMA (weights/pixels).
- Closes each job with the four-phase complete/ack exchange and provides status and watchdog error reporting.

---
 rtl/cnn_layer_accel_job_ctrl_pkg.sv | 23 ++
 rtl/cnn_layer_accel_job_ctrl_if.sv | 40 ++++
 rtl/cnn_layer_accel_job_ctrl_fifo.sv | 56 +++++
 rtl/cnn_layer_accel_job_ctrl.sv | 135 +++++++++++++
 tb/tb_cnn_layer_accel_job_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_job_ctrl_pkg.sv
// Shared types and defaults for the CNN layer accelerator job controller.
package cnn_layer_accel_ctrl_pkg;

    localparam int C_JOB_PARAM_W_DEFAULT = 128;
    localparam int C_TIMEOUT_DEFAULT     = 1048576;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FREQ,
        DMA_REQ,
        FETCH,
        WAIT_DONE,
        ACK,
        ERR
    } job_ctrl_state_t;

    // Every state that waits on an external party is guarded by the watchdog.
    function automatic logic wd_active(job_ctrl_state_t s);
        return (s != IDLE) && (s != ERR);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_job_ctrl_if.sv
// Host descriptor, quad job, DMA request and status signals of the job controller.
interface cnn_layer_accel_job_ctrl_if #(
    parameter int C_JOB_PARAM_W = cnn_layer_accel_ctrl_pkg::C_JOB_PARAM_W_DEFAULT,
    parameter int C_CNT_W       = 16
);
    logic                     desc_valid;
    logic                     desc_ready;
    logic [C_JOB_PARAM_W-1:0] desc_data;
    logic                     job_start;
    logic                     job_accept;
    logic [C_JOB_PARAM_W-1:0] job_parameters;
    logic                     job_fetch_request;
    logic                     job_fetch_ack;
    logic                     job_fetch_complete;
    logic                     job_complete;
    logic                     job_complete_ack;
    logic                     dma_req_valid;
    logic                     dma_req_ready;
    logic                     dma_done;
    logic                     busy;
    logic [C_CNT_W-1:0]       jobs_done;
    logic                     timeout_err;

    modport master (
        input  desc_valid, desc_data, job_accept, job_fetch_request,
               job_complete, dma_req_ready, dma_done,
        output desc_ready, job_start, job_parameters, job_fetch_ack,
               job_fetch_complete, job_complete_ack, dma_req_valid,
               busy, jobs_done, timeout_err
    );

    modport slave (
        output desc_valid, desc_data, job_accept, job_fetch_request,
               job_complete, dma_req_ready, dma_done,
        input  desc_ready, job_start, job_parameters, job_fetch_ack,
               job_fetch_complete, job_complete_ack, dma_req_valid,
               busy, jobs_done, timeout_err
    );

endinterface

// File: rtl/cnn_layer_accel_job_ctrl_fifo.sv
// Descriptor queue: synchronous FIFO with one push and one pop port.
module job_desc_fifo
    import cnn_layer_accel_ctrl_pkg::*;
#(
    parameter int C_WIDTH = C_JOB_PARAM_W_DEFAULT,
    parameter int C_DEPTH = 4
) (
    input  logic               clk_if,
    input  logic               rst,
    input  logic               push_i,
    input  logic [C_WIDTH-1:0] push_data_i,
    input  logic               pop_i,
    output logic [C_WIDTH-1:0] pop_data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int            C_AW   = $clog2(C_DEPTH);
    localparam logic [C_AW:0] C_FULL = (C_AW + 1)'(C_DEPTH);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_AW-1:0]    wr_ptr_q;
    logic [C_AW-1:0]    rd_ptr_q;
    logic [C_AW:0]      count_q;
    logic               push_ok;
    logic               pop_ok;

    assign full_o     = (count_q == C_FULL);
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is never read before it is written,
    // so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_if) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job sequencer in front of cnn_layer_accel_quad: queues host descriptors,
// issues them one at a time, brokers the fetch/DMA handshake and closes each job.
module cnn_layer_accel_job_ctrl
    import cnn_layer_accel_ctrl_pkg::*;
#(
    parameter int C_JOB_PARAM_W = C_JOB_PARAM_W_DEFAULT,
    parameter int C_QUEUE_DEPTH = 4,
    parameter int C_TIMEOUT     = C_TIMEOUT_DEFAULT,
    parameter int C_CNT_W       = 16
) (
    input  logic                      clk_if,
    input  logic                      rst,
    cnn_layer_accel_job_ctrl_if.master bus
);
    localparam int                C_WD_W    = $clog2(C_TIMEOUT);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(C_TIMEOUT - 1);

    job_ctrl_state_t          state_q;
    logic [C_WD_W-1:0]        wd_q;
    logic                     job_start_q;
    logic [C_JOB_PARAM_W-1:0] job_params_q;
    logic                     fetch_ack_q;
    logic                     fetch_complete_q;
    logic                     complete_ack_q;
    logic                     dma_req_valid_q;
    logic [C_CNT_W-1:0]       jobs_done_q;
    logic                     timeout_err_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [C_JOB_PARAM_W-1:0] fifo_head;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    job_desc_fifo #(
        .C_WIDTH (C_JOB_PARAM_W),
        .C_DEPTH (C_QUEUE_DEPTH)
    ) u_fifo (
        .clk_if      (clk_if),
        .rst         (rst),
        .push_i      (bus.desc_valid),
        .push_data_i (bus.desc_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q          <= IDLE;
            wd_q             <= '0;
            job_start_q      <= 1'b0;
            job_params_q     <= '0;
            fetch_ack_q      <= 1'b0;
            fetch_complete_q <= 1'b0;
            complete_ack_q   <= 1'b0;
            dma_req_valid_q  <= 1'b0;
            jobs_done_q      <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults followed by later overrides; the last
            // assignment in the block wins, which is how pulses and the
            // watchdog clear-on-transition are expressed.
            fetch_ack_q      <= 1'b0;
            fetch_complete_q <= 1'b0;
            wd_q             <= wd_active(state_q) ? wd_q + 1'b1 : '0;

            if (wd_active(state_q) && (wd_q == C_WD_LAST)) begin
                // Watchdog expiry beats any handshake seen in the same cycle.
                state_q         <= ERR;
                wd_q            <= '0;
                timeout_err_q   <= 1'b1;
                job_start_q     <= 1'b0;
                complete_ack_q  <= 1'b0;
                dma_req_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (!fifo_empty) begin
                        job_params_q <= fifo_head;
                        job_start_q  <= 1'b1;
                        state_q      <= START;
                        wd_q         <= '0;
                    end
                    START: if (bus.job_accept) begin
                        job_start_q <= 1'b0;
                        state_q     <= WAIT_FREQ;
                        wd_q        <= '0;
                    end
                    WAIT_FREQ: if (bus.job_fetch_request) begin
                        dma_req_valid_q <= 1'b1;
                        state_q         <= DMA_REQ;
                        wd_q            <= '0;
                    end
                    DMA_REQ: if (bus.dma_req_ready) begin
                        dma_req_valid_q <= 1'b0;
                        fetch_ack_q     <= 1'b1;
                        state_q         <= FETCH;
                        wd_q            <= '0;
                    end
                    FETCH: if (bus.dma_done) begin
                        fetch_complete_q <= 1'b1;
                        state_q          <= WAIT_DONE;
                        wd_q             <= '0;
                    end
                    WAIT_DONE: if (bus.job_complete) begin
                        complete_ack_q <= 1'b1;
                        state_q        <= ACK;
                        wd_q           <= '0;
                    end
                    ACK: if (!bus.job_complete) begin
                        complete_ack_q <= 1'b0;
                        jobs_done_q    <= jobs_done_q + 1'b1;
                        state_q        <= IDLE;
                        wd_q           <= '0;
                    end
                    ERR: state_q <= ERR;
                endcase
            end
        end
    end

    assign bus.desc_ready         = !fifo_full;
    assign bus.job_start          = job_start_q;
    assign bus.job_parameters     = job_params_q;
    assign bus.job_fetch_ack      = fetch_ack_q;
    assign bus.job_fetch_complete = fetch_complete_q;
    assign bus.job_complete_ack   = complete_ack_q;
    assign bus.dma_req_valid      = dma_req_valid_q;
    assign bus.busy               = (state_q != IDLE) || !fifo_empty;
    assign bus.jobs_done          = jobs_done_q;
    assign bus.timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for cnn_layer_accel_job_ctrl; inputs driven and outputs sampled on negedge.
module tb_cnn_layer_accel_job_ctrl;
    import cnn_layer_accel_ctrl_pkg::*;

    localparam int W     = 128;
    localparam int CNT_W = 16;
    localparam int TMO   = 64;

    logic clk_if = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   jobs_exp = 0;
    logic [W-1:0] q_desc [5];

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_ctrl_if #(.C_JOB_PARAM_W(W), .C_CNT_W(CNT_W)) bus ();

    cnn_layer_accel_job_ctrl #(
        .C_JOB_PARAM_W (W),
        .C_QUEUE_DEPTH (4),
        .C_TIMEOUT     (TMO),
        .C_CNT_W       (CNT_W)
    ) dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_if);
    endtask

    task automatic push(input logic [W-1:0] d);
        int n = 0;
        bus.desc_valid = 1'b1;
        bus.desc_data  = d;
        while (!bus.desc_ready && n < 100) begin
            step();
            n++;
        end
        check("push_ready", bus.desc_ready, 1);
        step();
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_start(input logic [W-1:0] exp);
        int n = 0;
        while (!bus.job_start && n < 100) begin
            step();
            n++;
        end
        check("job_start_seen", bus.job_start, 1);
        check("job_params", bus.job_parameters, exp);
    endtask

    task automatic accept_job(input int delay, input logic [W-1:0] exp);
        for (int i = 0; i < delay; i++) begin
            check("start_hold", bus.job_start, 1);
            check("params_hold", bus.job_parameters, exp);
            step();
        end
        bus.job_accept = 1'b1;
        step();
        bus.job_accept = 1'b0;
        check("start_drop", bus.job_start, 0);
    endtask

    task automatic request_fetch();
        bus.job_fetch_request = 1'b1;
        step();
        check("dma_req_valid_rise", bus.dma_req_valid, 1);
    endtask

    task automatic dma_handshake();
        bus.dma_req_ready = 1'b1;
        step();
        bus.dma_req_ready     = 1'b0;
        bus.job_fetch_request = 1'b0;
        check("dma_req_valid_drop", bus.dma_req_valid, 0);
        check("fetch_ack_pulse", bus.job_fetch_ack, 1);
        step();
        check("fetch_ack_end", bus.job_fetch_ack, 0);
    endtask

    task automatic finish_fetch();
        bus.dma_done = 1'b1;
        step();
        bus.dma_done = 1'b0;
        check("fetch_complete_pulse", bus.job_fetch_complete, 1);
        step();
        check("fetch_complete_end", bus.job_fetch_complete, 0);
    endtask

    task automatic complete_job(input int ack_cycles);
        bus.job_complete = 1'b1;
        step();
        check("complete_ack_rise", bus.job_complete_ack, 1);
        for (int i = 1; i < ack_cycles; i++) begin
            step();
            check("complete_ack_hold", bus.job_complete_ack, 1);
        end
        bus.job_complete = 1'b0;
        step();
        check("complete_ack_fall", bus.job_complete_ack, 0);
        jobs_exp++;
        check("jobs_done", bus.jobs_done, jobs_exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_desc_ready", bus.desc_ready, 1);
        check("rst_job_start", bus.job_start, 0);
        check("rst_job_params", bus.job_parameters, 0);
        check("rst_fetch_ack", bus.job_fetch_ack, 0);
        check("rst_fetch_complete", bus.job_fetch_complete, 0);
        check("rst_complete_ack", bus.job_complete_ack, 0);
        check("rst_dma_req_valid", bus.dma_req_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_jobs_done", bus.jobs_done, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        q_desc[0] = {4{32'h1000_0001}};
        q_desc[1] = {4{32'h2000_0002}};
        q_desc[2] = {4{32'h3000_0003}};
        q_desc[3] = {4{32'h4000_0004}};
        q_desc[4] = {4{32'h5000_0005}};

        rst                   = 1'b1;
        bus.desc_valid        = 1'b0;
        bus.desc_data         = '0;
        bus.job_accept        = 1'b0;
        bus.job_fetch_request = 1'b0;
        bus.job_complete      = 1'b0;
        bus.dma_req_ready     = 1'b0;
        bus.dma_done          = 1'b0;
        step(2);
        check_reset_outputs();
        rst = 1'b0;
        step();

        // Single job with immediate responders and latency checks.
        push({4{32'hA5A5_A5A5}});
        check("t1_start_not_yet", bus.job_start, 0);
        check("t1_busy_queued", bus.busy, 1);
        step();
        check("t1_start_latency", bus.job_start, 1);
        wait_start({4{32'hA5A5_A5A5}});
        accept_job(0, {4{32'hA5A5_A5A5}});
        request_fetch();
        dma_handshake();
        finish_fetch();
        complete_job(1);
        check("t1_busy_end", bus.busy, 0);

        // Stray dma_done while waiting for the fetch request is ignored.
        push({4{32'h1111_1111}});
        wait_start({4{32'h1111_1111}});
        accept_job(0, {4{32'h1111_1111}});
        bus.dma_done = 1'b1;
        step();
        bus.dma_done = 1'b0;
        check("stray_no_fetch_complete", bus.job_fetch_complete, 0);
        check("stray_no_dma_req", bus.dma_req_valid, 0);
        step();
        check("stray_no_fetch_complete2", bus.job_fetch_complete, 0);
        request_fetch();
        dma_handshake();
        finish_fetch();
        complete_job(1);

        // Stretched accept (20 cycles) and completion held for 7 ack cycles.
        push({4{32'h2222_2222}});
        wait_start({4{32'h2222_2222}});
        accept_job(20, {4{32'h2222_2222}});
        request_fetch();
        dma_handshake();
        finish_fetch();
        complete_job(7);

        // Queue fills while the first job is stalled in START.
        for (int i = 0; i < 5; i++) push(q_desc[i]);
        check("q_full_ready", bus.desc_ready, 0);
        check("q_busy", bus.busy, 1);
        check("q_first_inflight", bus.job_parameters, q_desc[0]);
        for (int i = 0; i < 5; i++) begin
            wait_start(q_desc[i]);
            accept_job(0, q_desc[i]);
            request_fetch();
            dma_handshake();
            finish_fetch();
            complete_job(1);
        end
        check("q_drained_busy", bus.busy, 0);

        // Watchdog: dma_done never arrives.
        push({4{32'hDEAD_BEEF}});
        wait_start({4{32'hDEAD_BEEF}});
        accept_job(0, {4{32'hDEAD_BEEF}});
        request_fetch();
        dma_handshake();
        k = 0;
        while (!bus.timeout_err && k < 200) begin
            step();
            k++;
        end
        check("wd_fetch_cycles", k, TMO - 1);
        check("wd_err", bus.timeout_err, 1);
        push({4{32'h7777_7777}});
        push({4{32'h8888_8888}});
        for (int i = 0; i < 10; i++) begin
            step();
            check("wd_no_start", bus.job_start, 0);
        end
        check("wd_ready_queue", bus.desc_ready, 1);
        check("wd_busy", bus.busy, 1);
        check("wd_dma_idle", bus.dma_req_valid, 0);
        check("wd_ack_idle", bus.job_complete_ack, 0);
        check("wd_err_sticky", bus.timeout_err, 1);

        // Reset clears the error and everything else.
        rst = 1'b1;
        step();
        check_reset_outputs();
        rst = 1'b0;
        jobs_exp = 0;
        step();

        // Reset in DMA_REQ with two descriptors queued.
        push({4{32'hC0C0_C0C0}});
        push({4{32'hC1C1_C1C1}});
        push({4{32'hC2C2_C2C2}});
        wait_start({4{32'hC0C0_C0C0}});
        accept_job(0, {4{32'hC0C0_C0C0}});
        request_fetch();
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        bus.job_fetch_request = 1'b0;
        step();
        check_reset_outputs();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_queue_empty", bus.busy, 0);
            check("mid_no_start", bus.job_start, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
